// File: rtl/ysyx_220053_trap_ctrl.sv
// Machine-mode trap sequencer: takes ecall/mret/timer interrupts at instruction
// boundaries, flushes and drains the pipeline, commits to the CSR file, then redirects fetch.
module ysyx_220053_trap_ctrl #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ecall_req,
  input  logic            mret_req,
  input  logic            timer_irq,
  input  logic            mstatus_mie,
  input  logic            mie_mtie,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            drain_done,
  input  logic            redirect_ready,
  output logic            busy,
  output logic            flush,
  output logic            csr_ecall,
  output logic            csr_mret,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_cause,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FLUSH, COMMIT, REDIRECT} state_e;
  typedef enum logic [1:0] {KIND_ECALL, KIND_MRET, KIND_IRQ} kind_e;

  localparam logic [3:0]      FLUSH_LAST  = 4'(FLUSH_CYCLES - 1);
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_MTI   = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] VEC_OFFSET  = XLEN'(28);

  state_e          state_q, state_d;
  kind_e           kind_q, kind_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            irq_take_s;

  // Vectored mode lands the timer interrupt at base + 4*7; everything else uses the base.
  function automatic logic [XLEN-1:0] redirect_target(input kind_e kind,
                                                      input logic [XLEN-1:0] tvec,
                                                      input logic [XLEN-1:0] epc);
    logic [XLEN-1:0] base;
    base = {tvec[XLEN-1:2], 2'b00};
    case (kind)
      KIND_MRET: redirect_target = epc;
      KIND_IRQ: begin
        if (tvec[1:0] == 2'b01) redirect_target = base + VEC_OFFSET;
        else                    redirect_target = base;
      end
      default: redirect_target = base;
    endcase
  endfunction

  assign irq_take_s = timer_irq & mstatus_mie & mie_mtie;

  // Next-state and latch logic for the trap sequence.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        rpc_d = {XLEN{1'b0}};
        if (pc_valid && (ecall_req || mret_req || irq_take_s)) begin
          state_d = FLUSH;
          if (ecall_req) begin
            kind_d  = KIND_ECALL;
            epc_d   = pc_in;
            cause_d = CAUSE_ECALL;
          end else if (mret_req) begin
            kind_d  = KIND_MRET;
          end else begin
            kind_d  = KIND_IRQ;
            epc_d   = pc_in;
            cause_d = CAUSE_MTI;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
        else                cnt_d = cnt_q;
        if ((cnt_q >= FLUSH_LAST) && drain_done) state_d = COMMIT;
        else                                     state_d = FLUSH;
      end
      COMMIT: begin
        rpc_d   = redirect_target(kind_q, mtvec, mepc);
        state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
          rpc_d   = {XLEN{1'b0}};
        end else begin
          state_d = REDIRECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched trap context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kind_q  <= KIND_ECALL;
      cnt_q   <= 4'd0;
      epc_q   <= {XLEN{1'b0}};
      cause_q <= {XLEN{1'b0}};
      rpc_q   <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      rpc_q   <= rpc_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign flush          = (state_q == FLUSH);
  assign csr_ecall      = (state_q == COMMIT) && (kind_q != KIND_MRET);
  assign csr_mret       = (state_q == COMMIT) && (kind_q == KIND_MRET);
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = rpc_q;
  assign trap_epc       = epc_q;
  assign trap_cause     = cause_q;

endmodule
